// File: rtl/pe_tile_scheduler_if.sv
// Job-descriptor handshake between a host (master) and the tile scheduler (slave).
interface pe_tile_scheduler_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_src_base;
   logic [31:0] cmd_dst_base;
   logic [15:0] cmd_num_tiles;

   modport master (output cmd_valid, cmd_src_base, cmd_dst_base, cmd_num_tiles,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_num_tiles,
                   output cmd_ready);
endinterface

// File: rtl/pe_tile_scheduler.sv
// Runs a multi-tile job on one PE-array controller: one start per tile, and
// relocates the controller's local address into the shared memory map.
module pe_tile_scheduler #(
   parameter int VECTOR_SIZE = 16,
   parameter int MATRIX_SIZE = 16,
   parameter int SRC_STRIDE  = (MATRIX_SIZE + 1) * VECTOR_SIZE,
   parameter int DST_STRIDE  = MATRIX_SIZE,
   parameter int TIMEOUT     = 4096
) (
   input  logic                  aclk,
   input  logic                  areset,
   pe_tile_scheduler_if.slave    cmd_if,
   input  logic                  abort,
   output logic                  busy,
   output logic                  job_done,
   output logic                  job_err,
   output logic [15:0]           tiles_done,
   output logic                  pe_start,
   input  logic                  pe_done,
   input  logic                  pe_write,
   input  logic [31:0]           pe_raddr,
   output logic [31:0]           mem_addr,
   output logic                  mem_we
);
   localparam int WDW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, NEXT, FIN} state_t;

   state_t           state, state_nx;
   logic [31:0]      src_base, dst_base, src_off, dst_off;
   logic [15:0]      num_tiles;
   logic [WDW-1:0]   wdog;
   logic             abort_pending, err_q;
   logic             accept, timeout, last_tile, stop_req;

   assign accept    = cmd_if.cmd_valid && (state == IDLE);
   assign timeout   = !pe_done && (wdog == WDW'(TIMEOUT - 1));
   assign last_tile = (tiles_done + 16'd1) == num_tiles;
   assign stop_req  = abort_pending || abort;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (cmd_if.cmd_num_tiles == 16'd0) ? FIN : START;
         START:   state_nx = RUN;
         RUN:     if (pe_done) state_nx = DRAIN;
                  else if (timeout) state_nx = FIN;
         // controller must be back in idle before it can see the next start
         DRAIN:   if (!pe_done) state_nx = NEXT;
         NEXT:    state_nx = (stop_req || last_tile) ? FIN : START;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cmd_if.cmd_ready = (state == IDLE);
      busy             = (state != IDLE);
      pe_start         = (state == START);
      job_done         = (state == FIN);
      job_err          = (state == FIN) && err_q;
      mem_we           = 1'b0;
      mem_addr         = 32'd0;
      if (state == RUN || state == DRAIN) begin
         mem_we   = pe_write;
         mem_addr = pe_write ? (dst_base + dst_off + pe_raddr)
                             : (src_base + src_off + pe_raddr);
      end
   end

   // offsets advance by accumulation so no multiplier is needed
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         src_base      <= 32'd0;
         dst_base      <= 32'd0;
         num_tiles     <= 16'd0;
         src_off       <= 32'd0;
         dst_off       <= 32'd0;
         tiles_done    <= 16'd0;
         wdog          <= '0;
         abort_pending <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               src_base      <= cmd_if.cmd_src_base;
               dst_base      <= cmd_if.cmd_dst_base;
               num_tiles     <= cmd_if.cmd_num_tiles;
               src_off       <= 32'd0;
               dst_off       <= 32'd0;
               tiles_done    <= 16'd0;
               wdog          <= '0;
               abort_pending <= 1'b0;
               err_q         <= 1'b0;
            end
            START: if (abort) abort_pending <= 1'b1;
            RUN: begin
               if (abort) abort_pending <= 1'b1;
               wdog <= wdog + 1'b1;
               if (!pe_done && timeout) err_q <= 1'b1;
            end
            DRAIN: if (abort) abort_pending <= 1'b1;
            NEXT: begin
               tiles_done <= tiles_done + 16'd1;
               src_off    <= src_off + 32'(SRC_STRIDE);
               dst_off    <= dst_off + 32'(DST_STRIDE);
               wdog       <= '0;
               if (stop_req) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Scoreboard bench for pe_tile_scheduler: directed jobs against a simple PE model.
module tb_pe_tile_scheduler;
   localparam int TIMEOUT = 4096;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        abort = 1'b0;
   logic        pe_done = 1'b0;
   logic        pe_write = 1'b0;
   logic [31:0] pe_raddr = 32'd0;
   logic        busy, job_done, job_err, pe_start, mem_we;
   logic [15:0] tiles_done;
   logic [31:0] mem_addr;

   pe_tile_scheduler_if cmd_if();

   pe_tile_scheduler #(.TIMEOUT(TIMEOUT)) dut (
      .aclk(aclk), .areset(areset), .cmd_if(cmd_if), .abort(abort),
      .busy(busy), .job_done(job_done), .job_err(job_err), .tiles_done(tiles_done),
      .pe_start(pe_start), .pe_done(pe_done), .pe_write(pe_write),
      .pe_raddr(pe_raddr), .mem_addr(mem_addr), .mem_we(mem_we));

   always #5 aclk = ~aclk;

   typedef struct packed {logic err; logic [15:0] tiles;} exp_t;
   exp_t sb[$];

   int tests = 0, fails = 0, cyc = 0, starts = 0, dones = 0;
   int last_start_cyc = 0, last_done_cyc = 0;
   int pe_lat = 600, pe_hold = 6;
   bit pe_never = 1'b0, pe_kill = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // PE controller model: done after pe_lat cycles, held pe_hold cycles
   initial begin
      forever begin
         @(negedge aclk);
         if (pe_start === 1'b1 && !pe_never) begin
            for (int i = 0; i < pe_lat && !pe_kill; i++) begin @(posedge aclk); #1; end
            if (!pe_kill) begin
               pe_done = 1'b1;
               for (int i = 0; i < pe_hold && !pe_kill; i++) begin @(posedge aclk); #1; end
            end
            pe_done = 1'b0;
         end
      end
   end

   // monitor: pops the scoreboard on every job_done
   always @(negedge aclk) begin
      exp_t e;
      cyc++;
      if (pe_start === 1'b1) begin
         starts++;
         last_start_cyc = cyc;
         chk("start_while_pe_done", {31'd0, pe_done}, 32'd0);
      end
      if (job_done === 1'b1) begin
         dones++;
         last_done_cyc = cyc;
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_job_done: tiles_done=%0d err=%0b, no job expected",
                     tiles_done, job_err);
         end else begin
            e = sb.pop_front();
            chk("job_err", {31'd0, job_err}, {31'd0, e.err});
            chk("tiles_done", {16'd0, tiles_done}, {16'd0, e.tiles});
         end
      end
   end

   task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      @(posedge aclk); #1;
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_src_base = s;
      cmd_if.cmd_dst_base = d; cmd_if.cmd_num_tiles = n;
      @(posedge aclk); #1;
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input int target);
      for (int i = 0; i < 5000 && starts < target; i++) begin @(negedge aclk); #1; end
      if (starts < target) begin
         tests++; fails++;
         $display("FAIL wait_start: got %0d starts, want %0d", starts, target);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20000 && busy; i++) @(negedge aclk);
      if (busy) begin
         tests++; fails++;
         $display("FAIL wait_idle: busy still 1, want 0");
      end
   endtask

   initial begin
      int s0;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_src_base = 32'd0;
      cmd_if.cmd_dst_base = 32'd0; cmd_if.cmd_num_tiles = 16'd0;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(negedge aclk);
      chk("rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_job_done", {31'd0, job_done}, 32'd0);
      chk("rst_job_err", {31'd0, job_err}, 32'd0);
      chk("rst_tiles_done", {16'd0, tiles_done}, 32'd0);
      chk("rst_pe_start", {31'd0, pe_start}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);

      // 3-tile job, address relocation on tile 2, descriptor ignored while busy
      s0 = starts;
      sb.push_back('{1'b0, 16'd3});
      issue(32'h1000, 32'h8000, 16'd3);
      wait_start(s0 + 2);
      @(posedge aclk); #1;
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_num_tiles = 16'd0;
      @(negedge aclk);
      chk("busy_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      repeat (3) @(posedge aclk);
      #1 cmd_if.cmd_valid = 1'b0;
      wait_start(s0 + 3);
      @(posedge aclk); #1 pe_raddr = 32'd5; pe_write = 1'b0;
      @(negedge aclk);
      chk("reloc_src", mem_addr, 32'h1225);
      chk("reloc_src_we", {31'd0, mem_we}, 32'd0);
      @(posedge aclk); #1 pe_write = 1'b1;
      @(negedge aclk);
      chk("reloc_dst", mem_addr, 32'h8025);
      chk("reloc_dst_we", {31'd0, mem_we}, 32'd1);
      @(posedge aclk); #1 pe_write = 1'b0; pe_raddr = 32'd0;
      wait_idle();
      chk("job3_starts", starts - s0, 32'd3);
      chk("job3_tiles_hold", {16'd0, tiles_done}, 32'd3);
      chk("idle_mem_addr", mem_addr, 32'd0);

      // zero-tile job
      s0 = starts;
      sb.push_back('{1'b0, 16'd0});
      issue(32'h4000, 32'h5000, 16'd0);
      @(negedge aclk);
      chk("zero_done_lat", {31'd0, job_done}, 32'd1);
      wait_idle();
      chk("zero_starts", starts - s0, 32'd0);

      // abort during tile 0 of a 4-tile job
      s0 = starts;
      sb.push_back('{1'b1, 16'd1});
      issue(32'h2000, 32'h9000, 16'd4);
      wait_start(s0 + 1);
      repeat (20) @(posedge aclk);
      #1 abort = 1'b1;
      @(posedge aclk); #1 abort = 1'b0;
      wait_idle();
      chk("abort_starts", starts - s0, 32'd1);

      // controller never finishes: watchdog, plus address wrap
      pe_never = 1'b1;
      s0 = starts;
      sb.push_back('{1'b1, 16'd0});
      issue(32'hFFFF_FFF0, 32'd0, 16'd2);
      wait_start(s0 + 1);
      @(posedge aclk); #1 pe_raddr = 32'h15;
      @(negedge aclk);
      chk("wrap_addr", mem_addr, 32'h0000_0005);
      @(posedge aclk); #1 pe_raddr = 32'd0;
      wait_idle();
      chk("timeout_len", last_done_cyc - last_start_cyc, TIMEOUT + 1);
      chk("timeout_starts", starts - s0, 32'd1);
      pe_never = 1'b0;

      // reset in tile 1 of a 3-tile job
      s0 = starts;
      issue(32'h1000, 32'h8000, 16'd3);
      wait_start(s0 + 2);
      repeat (10) @(posedge aclk);
      #1 pe_raddr = 32'd7; areset = 1'b1; pe_kill = 1'b1;
      @(negedge aclk);
      chk("mid_rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_tiles_done", {16'd0, tiles_done}, 32'd0);
      chk("mid_rst_mem_addr", mem_addr, 32'd0);
      chk("mid_rst_pe_start", {31'd0, pe_start}, 32'd0);
      chk("mid_rst_job_done", {31'd0, job_done}, 32'd0);
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0; pe_kill = 1'b0; pe_raddr = 32'd0;

      // abort while idle has no effect on the following job
      @(posedge aclk); #1 abort = 1'b1;
      @(posedge aclk); #1 abort = 1'b0;
      s0 = starts;
      sb.push_back('{1'b0, 16'd1});
      issue(32'h3000, 32'hA000, 16'd1);
      wait_idle();
      chk("post_rst_starts", starts - s0, 32'd1);
      chk("post_rst_tiles", {16'd0, tiles_done}, 32'd1);

      repeat (3) @(negedge aclk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
